// File: rtl/nios_project_led_sequencer.sv
// rtl/nios_project_led_sequencer.sv - Avalon-MM configurable LED pattern sequencer
// Steps through up to eight 4-bit patterns, writing each to an LED PIO slave and dwelling between writes.
module nios_project_led_sequencer #(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         s_address,
    input  logic               s_chipselect,
    input  logic               s_write_n,
    input  logic [31:0]        s_writedata,
    output logic [31:0]        s_readdata,
    output logic [1:0]         m_address,
    output logic               m_chipselect,
    output logic               m_write_n,
    output logic [31:0]        m_writedata,
    output logic               irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    state_t               state_q;
    logic                 run_q;
    logic                 loop_q;
    logic                 irq_en_q;
    logic                 done_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [2:0]           length_q;
    logic [3:0]           pattern_q [0:7];
    logic [2:0]           idx_q;
    logic [DWELL_W-1:0]   cnt_q;

    logic                 wr_en;
    logic                 wr_ctrl;
    logic                 wr_status;
    logic                 wr_dwell;
    logic                 wr_length;
    logic                 wr_pattern;
    logic                 busy;
    logic [DWELL_W-1:0]   cnt_load_d;
    logic                 wdata_unused;

    assign wr_en      = s_chipselect & ~s_write_n;
    assign wr_ctrl    = wr_en && (s_address == 4'd0);
    assign wr_status  = wr_en && (s_address == 4'd1);
    assign wr_dwell   = wr_en && (s_address == 4'd2);
    assign wr_length  = wr_en && (s_address == 4'd3);
    assign wr_pattern = wr_en && s_address[3];
    assign busy       = (state_q != ST_IDLE);
    assign wdata_unused = &{1'b0, s_writedata};

    // A zero DWELL behaves as one, so the counter load never underflows.
    assign cnt_load_d = (dwell_q == '0) ? '0 : dwell_q - {{(DWELL_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            dwell_q  <= '0;
            length_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                pattern_q[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                run_q    <= s_writedata[0];
                loop_q   <= s_writedata[1];
                irq_en_q <= s_writedata[2];
            end
            if (wr_dwell) begin
                dwell_q <= s_writedata[DWELL_W-1:0];
            end
            if (wr_length) begin
                length_q <= s_writedata[2:0];
            end
            if (wr_pattern) begin
                pattern_q[s_address[2:0]] <= s_writedata[3:0];
            end
            if (wr_status && s_writedata[1]) begin
                done_q <= 1'b0;
            end

            // Later assignments below deliberately override the software clear of done.
            case (state_q)
                ST_IDLE: begin
                    if (run_q) begin
                        state_q <= ST_WRITE;
                        idx_q   <= '0;
                        done_q  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (!run_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DWELL;
                        cnt_q   <= cnt_load_d;
                    end
                end
                ST_DWELL: begin
                    if (!run_q) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        if (idx_q >= length_q) begin
                            if (loop_q) begin
                                idx_q   <= '0;
                                state_q <= ST_WRITE;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                                if (!wr_ctrl) begin
                                    run_q <= 1'b0;
                                end
                            end
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= ST_WRITE;
                        end
                    end else begin
                        cnt_q <= cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0: s_readdata[2:0] = {irq_en_q, loop_q, run_q};
            4'd1: begin
                s_readdata[0]   = busy;
                s_readdata[1]   = done_q;
                s_readdata[6:4] = idx_q;
            end
            4'd2: s_readdata[DWELL_W-1:0] = dwell_q;
            4'd3: s_readdata[2:0] = length_q;
            default: begin
                if (s_address[3]) begin
                    s_readdata[3:0] = pattern_q[s_address[2:0]];
                end
            end
        endcase
    end

    assign m_address    = 2'd0;
    assign m_chipselect = (state_q == ST_WRITE);
    assign m_write_n    = ~m_chipselect;
    assign m_writedata  = m_chipselect ? {28'd0, pattern_q[idx_q]} : 32'd0;
    assign irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_nios_project_led_sequencer.sv
// tb/tb_nios_project_led_sequencer.sv - directed self-checking bench for the LED sequencer
module tb_nios_project_led_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hit_cyc = 0;
    logic [31:0] wq [$];
    int          wc [$];

    nios_project_led_sequencer #(.DWELL_W(24)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_chipselect && !m_write_n) begin
            wq.push_back(m_writedata);
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        s_address = a;
        #1 d = s_readdata;
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val,
                               input int budget, input string tag);
        logic hit;
        hit = 1'b0;
        s_address = 4'd1;
        for (int k = 0; k < budget && !hit; k++) begin
            @(posedge clk);
            #1;
            if ((s_readdata & mask) == val) begin
                hit = 1'b1;
                hit_cyc = cyc;
            end
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(posedge clk);
            #1;
            if (wq.size() >= n) hit = 1'b1;
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          base;
        int          nw;
        logic        hit;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", {31'd0, m_chipselect}, 32'd0);
        chk("rst_wn", {31'd0, m_write_n}, 32'd1);
        chk("rst_wdata", m_writedata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_maddr", {30'd0, m_address}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(4'd1, d); chk("rst_status", d, 32'd0);

        // Three-step one-shot sequence
        wr(4'd8, 32'h1);
        wr(4'd9, 32'h2);
        wr(4'd10, 32'h4);
        wr(4'd3, 32'd2);
        wr(4'd2, 32'd3);
        rd(4'd2, d); chk("dwell_rb", d, 32'd3);
        rd(4'd3, d); chk("length_rb", d, 32'd2);
        rd(4'd9, d); chk("pat1_rb", d, 32'd2);
        wq.delete(); wc.delete();
        wr(4'd0, 32'h1);
        wait_status(32'h3, 32'h2, 100, "oneshot_done_timeout");
        chk("oneshot_nwrites", wq.size(), 32'd3);
        if (wq.size() == 3) begin
            chk("oneshot_w0", wq[0], 32'h1);
            chk("oneshot_w1", wq[1], 32'h2);
            chk("oneshot_w2", wq[2], 32'h4);
            chk("oneshot_gap01", wc[1] - wc[0], 32'd4);
            chk("oneshot_gap12", wc[2] - wc[1], 32'd4);
        end
        rd(4'd1, d); chk("oneshot_status", d, 32'h22);
        rd(4'd0, d); chk("oneshot_ctrl", d, 32'h0);
        chk("oneshot_irq", {31'd0, irq}, 32'd0);

        // Looping sequence, then stop during a dwell
        wr(4'd1, 32'h2);
        wq.delete(); wc.delete();
        wr(4'd0, 32'h3);
        wait_writes(5, 200, "loop_timeout");
        wr(4'd0, 32'h0);
        repeat (20) @(negedge clk);
        chk("loop_nwrites", wq.size(), 32'd5);
        if (wq.size() == 5) begin
            chk("loop_w3", wq[3], 32'h1);
            chk("loop_w4", wq[4], 32'h2);
            chk("loop_gap34", wc[4] - wc[3], 32'd4);
        end
        rd(4'd1, d); chk("loop_stop_status", d, 32'h10);

        // Zero dwell, single step, interrupt
        wr(4'd2, 32'd0);
        wr(4'd3, 32'd0);
        wr(4'd8, 32'hF);
        wq.delete(); wc.delete();
        wr(4'd0, 32'h5);
        wait_status(32'h2, 32'h2, 50, "zd_done_timeout");
        chk("zd_nwrites", wq.size(), 32'd1);
        if (wq.size() == 1) begin
            chk("zd_w0", wq[0], 32'hF);
            chk("zd_latency", hit_cyc - wc[0], 32'd2);
        end
        chk("zd_irq_set", {31'd0, irq}, 32'd1);
        rd(4'd1, d); chk("zd_status", d, 32'h02);
        wr(4'd1, 32'h2);
        rd(4'd1, d); chk("zd_status_clr", d, 32'h00);
        chk("zd_irq_clr", {31'd0, irq}, 32'd0);

        // Shorten LENGTH while running past it
        wr(4'd2, 32'd3);
        wr(4'd3, 32'd7);
        wq.delete(); wc.delete();
        wr(4'd0, 32'h1);
        wait_status(32'h70, 32'h50, 200, "len_idx5_timeout");
        wr(4'd3, 32'd2);
        wait_status(32'h2, 32'h2, 50, "len_done_timeout");
        chk("len_nwrites", wq.size(), 32'd6);
        rd(4'd1, d); chk("len_status", d, 32'h52);

        // Done set by hardware on the same edge as a software clear
        wr(4'd1, 32'h2);
        wr(4'd3, 32'd0);
        wq.delete(); wc.delete();
        wr(4'd0, 32'h1);
        wait_writes(1, 50, "race_timeout");
        base = (wc.size() > 0) ? wc[0] : cyc;
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (cyc == base + 3) hit = 1'b1;
        end
        chk("race_align", {31'd0, hit}, 32'd1);
        s_address    = 4'd1;
        s_writedata  = 32'h2;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        rd(4'd1, d); chk("race_status", d, 32'h02);

        // Reset asserted during a master write cycle
        wr(4'd0, 32'h3);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(posedge clk);
            #1;
            if (m_chipselect) hit = 1'b1;
        end
        chk("rstw_reach_write", {31'd0, hit}, 32'd1);
        nw = wq.size();
        #2 reset_n = 1'b0;
        #1;
        chk("rstw_cs", {31'd0, m_chipselect}, 32'd0);
        chk("rstw_wn", {31'd0, m_write_n}, 32'd1);
        chk("rstw_wdata", m_writedata, 32'd0);
        chk("rstw_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("rstw_no_write", wq.size(), nw);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            if (a < 4 || a >= 8) begin
                rd(a[3:0], d);
                chk($sformatf("rstw_reg%0d", a), d, 32'd0);
            end
        end
        repeat (10) @(negedge clk);
        chk("rstw_idle_writes", wq.size(), nw);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nios_project_led_sequencer.md
NIOS_PROJECT_LED_SEQUENCER -- requirements
Module: nios_project_led_sequencer

Interface
REQ-001 Parameter DWELL_W, default 24, width of the dwell counter and DWELL register.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 s_address  input  4  Avalon-MM slave word address (configuration port).
REQ-005 s_chipselect  input  1  slave select.
REQ-006 s_write_n  input  1  slave write strobe, active-low.
REQ-007 s_writedata  input  32  slave write data.
REQ-008 s_readdata  output  32  slave read data; combinational, zero wait states, unused bits 0.
REQ-009 m_address  output  2  master address to the LED PIO slave; constant 0.
REQ-010 m_chipselect  output  1  master select to the LED PIO slave.
REQ-011 m_write_n  output  1  master write strobe, active-low.
REQ-012 m_writedata  output  32  master write data: {28'b0, pattern[3:0]}.
REQ-013 irq  output  1  level interrupt = done AND irq_en.

Function
REQ-014 The register map SHALL be: 0 CTRL {bit0 run, bit1 loop, bit2 irq_en} RW; 1 STATUS {bit0 busy, bit1 done, bits[6:4] idx} R, a write with bit1=1 clears done; 2 DWELL [DWELL_W-1:0] RW; 3 LENGTH [2:0] RW (last step index); 8..15 PATTERN[0..7] [3:0] RW; other addresses read 0 and ignore writes.
REQ-015 A slave write SHALL occur when s_chipselect=1 and s_write_n=0 and take effect on that clock edge.
REQ-016 The FSM SHALL have states IDLE, WRITE, DWELL; busy=1 in WRITE and DWELL.
REQ-017 IDLE->WRITE when run=1; idx SHALL be set to 0 and done cleared on this transition.
REQ-018 In WRITE, for exactly one cycle, m_chipselect=1, m_write_n=0, m_writedata[3:0]=PATTERN[idx] as sampled that cycle; otherwise m_chipselect=0, m_write_n=1, m_writedata=0.
REQ-019 WRITE->DWELL unconditionally (unless REQ-022), loading the counter with DWELL_eff-1, where DWELL_eff = DWELL when DWELL != 0, else 1.
REQ-020 DWELL SHALL decrement the counter each cycle; at counter 0: if idx >= LENGTH then (loop=1: idx<=0, ->WRITE; loop=0: done<=1, run<=0, ->IDLE), else idx<=idx+1, ->WRITE.
REQ-021 Consecutive master writes SHALL be spaced exactly DWELL_eff+1 cycles apart.
REQ-022 If run=0 at a clock edge while in WRITE or DWELL, the FSM SHALL go to IDLE on that edge with no further master write, done unchanged, idx held; this has priority over REQ-019/020.
REQ-023 A CTRL write with run=1 while busy SHALL NOT restart the sequence; loop and irq_en updates apply immediately.
REQ-024 PATTERN, DWELL and LENGTH writes while busy SHALL apply at the next WRITE sample, next counter load, and next end-of-step compare respectively.
REQ-025 Hardware run clear (REQ-020) and a same-cycle software CTRL write SHALL resolve in favour of the software write value.
REQ-026 Hardware done set and a same-cycle software done clear SHALL resolve with done=1.

Reset
REQ-027 On reset_n=0, asynchronously: FSM=IDLE, CTRL=0, DWELL=0, LENGTH=0, all PATTERN=0, idx=0, counter=0, done=0, m_chipselect=0, m_write_n=1, m_writedata=0, irq=0.
REQ-028 Reset mid-sequence SHALL abort immediately with no master write issued after assertion.

Verification
REQ-029 PATTERN0..2=1,2,4, LENGTH=2, DWELL=3, CTRL=1 -> master writes 0x1,0x2,0x4 spaced 4 cycles; done=1, run=0, busy=0 after final dwell.
REQ-030 Same setup with CTRL=0x3 -> sequence 1,2,4,1,2,... continuous; CTRL=0 during DWELL -> no further writes, done=0, STATUS idx holds value.
REQ-031 DWELL=0, LENGTH=0, PATTERN0=0xF, CTRL=0x5 -> one write of 0xF, DWELL lasts 1 cycle, done=1, irq=1; STATUS write 0x2 -> done=0, irq=0.
REQ-032 Running with idx=5, write LENGTH=2 -> sequence ends after current step (idx>=LENGTH), done=1.
REQ-033 Assert reset_n=0 in WRITE cycle -> m_chipselect=0, m_write_n=1 immediately; all registers read 0 afterwards.
REQ-034 Same-cycle hardware done set and STATUS write 0x2 -> done reads 1.
